// File: rtl/dac_fmt_pkg.sv
// Shared constants and helpers for the DAC output formatter.
// Holds the default parameter values and the effective-shift clamp
// used by the formatter stages.
package dac_fmt_pkg;

  localparam int IN_WIDTH_DEF      = 32;
  localparam int OUT_WIDTH_DEF     = 8;
  localparam int SHIFT_WIDTH_DEF   = 5;
  localparam int BASE_SHIFT_DEF    = 12;
  localparam int OVF_CNT_WIDTH_DEF = 16;

  // Total right shift, clamped so it never exceeds the sample width.
  // The sum is done in int, so a large runtime shift cannot wrap to a small value.
  function automatic int eff_shift(input int base_shift, input int shift, input int in_width);
    int s;
    s = base_shift + shift;
    if (s > in_width - 1) begin
      s = in_width - 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/axis_dac_scaler_if.sv
// AXI-Stream beat bundle (tdata/tvalid/tlast/tready) for the formatter ports.
// master drives data/valid/last and samples ready; slave is the mirror.
// WIDTH sets tdata width, so one interface serves both the wide and the narrow side.
interface axis_dac_scaler_if
  import dac_fmt_pkg::*;
#(
  parameter int WIDTH = OUT_WIDTH_DEF
);

  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/dac_sat_narrow.sv
// Narrows a wide signed sample to the DAC width (clamp or wrap), then optional offset-binary.
// Latency: purely combinational. Backpressure: none, no handshake.
// Ports: y (wide signed), sat_en, offset_bin -> tdata (narrow), ovf (y out of narrow range).
module dac_sat_narrow
  import dac_fmt_pkg::*;
#(
  parameter int Y_WIDTH   = IN_WIDTH_DEF + 1,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic signed [Y_WIDTH-1:0]   y,
  input  logic                        sat_en,
  input  logic                        offset_bin,
  output logic        [OUT_WIDTH-1:0] tdata,
  output logic                        ovf
);

  // y fits in OUT_WIDTH signed bits exactly when every bit from the narrow
  // sign bit upward is a copy of the sign.
  logic [Y_WIDTH-OUT_WIDTH:0] hi;
  logic [OUT_WIDTH-1:0]       narrowed;

  always_comb begin
    hi       = y[Y_WIDTH-1:OUT_WIDTH-1];
    ovf      = !((&hi) || !(|hi));
    narrowed = y[OUT_WIDTH-1:0];
    if (ovf && sat_en) begin
      narrowed = y[Y_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                              : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
    tdata = {narrowed[OUT_WIDTH-1] ^ offset_bin, narrowed[OUT_WIDTH-2:0]};
  end

endmodule

// File: rtl/axis_dac_scaler.sv
// AXI-Stream formatter: signed arithmetic right shift (floor or round-half-up), narrow, offset-binary.
// Latency 2 cycles from accept to m00 valid; 1 beat/cycle when downstream is ready.
// Backpressure: two-stage elastic pipe, s00 tready drops only when both stages hold data and m00 stalls.
// Ports: s00_axis (wide in), m00_axis (narrow out), per-beat controls shift/round_en/sat_en/offset_bin,
//        overflow stats ovf_count/ovf_sticky with clr_ovf.
module axis_dac_scaler
  import dac_fmt_pkg::*;
#(
  parameter int IN_WIDTH      = IN_WIDTH_DEF,
  parameter int OUT_WIDTH     = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH   = SHIFT_WIDTH_DEF,
  parameter int BASE_SHIFT    = BASE_SHIFT_DEF,
  parameter int OVF_CNT_WIDTH = OVF_CNT_WIDTH_DEF
) (
  input  logic                     s00_axis_aclk,
  input  logic                     s00_axis_aresetn,
  axis_dac_scaler_if.slave         s00_axis,
  axis_dac_scaler_if.master        m00_axis,
  input  logic [SHIFT_WIDTH-1:0]   shift,
  input  logic                     round_en,
  input  logic                     sat_en,
  input  logic                     offset_bin,
  input  logic                     clr_ovf,
  output logic [OVF_CNT_WIDTH-1:0] ovf_count,
  output logic                     ovf_sticky
);

  // One guard bit on top of the input so the rounding add cannot overflow.
  localparam int Y_WIDTH  = IN_WIDTH + 1;
  localparam int SH_WIDTH = $clog2(IN_WIDTH) + 1;
  localparam logic [OVF_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic adv1;
  logic adv2;
  logic load2;

  // Stage 1: shifted sample plus the per-beat controls stage 2 still needs.
  logic                      v1;
  logic signed [Y_WIDTH-1:0] y1;
  logic                      last1;
  logic                      sat1;
  logic                      ob1;

  // Stage 2: formatted output beat.
  logic                 v2;
  logic [OUT_WIDTH-1:0] dat2;
  logic                 last2;

  logic [SH_WIDTH-1:0]       s_eff;
  logic signed [Y_WIDTH-1:0] x_ext;
  logic signed [Y_WIDTH-1:0] rnd_add;
  logic signed [Y_WIDTH-1:0] sum;
  logic signed [Y_WIDTH-1:0] y_next;

  logic [OUT_WIDTH-1:0] narrow_dat;
  logic                 narrow_ovf;

  // A stage may load when it is empty or when its content moves on this cycle.
  assign adv2  = !v2 || m00_axis.tready;
  assign adv1  = !v1 || adv2;
  assign load2 = adv2 && v1;

  assign s00_axis.tready = adv1;

  always_comb begin
    s_eff   = SH_WIDTH'(eff_shift(BASE_SHIFT, int'(shift), IN_WIDTH));
    x_ext   = {s00_axis.tdata[IN_WIDTH-1], s00_axis.tdata};
    rnd_add = '0;
    // Adding half an LSB of the result before flooring gives round-half-up.
    if (round_en && (s_eff != '0)) begin
      rnd_add = Y_WIDTH'(1) << (s_eff - SH_WIDTH'(1));
    end
    sum    = x_ext + rnd_add;
    y_next = sum >>> s_eff;
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      v1    <= 1'b0;
      y1    <= '0;
      last1 <= 1'b0;
      sat1  <= 1'b0;
      ob1   <= 1'b0;
    end else if (adv1) begin
      v1 <= s00_axis.tvalid;
      // Only capture on a real beat so the stage holds clean data while idle.
      if (s00_axis.tvalid) begin
        y1    <= y_next;
        last1 <= s00_axis.tlast;
        sat1  <= sat_en;
        ob1   <= offset_bin;
      end
    end
  end

  dac_sat_narrow #(
    .Y_WIDTH   (Y_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_narrow (
    .y          (y1),
    .sat_en     (sat1),
    .offset_bin (ob1),
    .tdata      (narrow_dat),
    .ovf        (narrow_ovf)
  );

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      v2    <= 1'b0;
      dat2  <= '0;
      last2 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        dat2  <= narrow_dat;
        last2 <= last1;
      end
    end
  end

  // Stats count beats as they enter stage 2; a clear takes priority.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (clr_ovf) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (load2 && narrow_ovf) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end
  end

  assign m00_axis.tvalid = v2;
  assign m00_axis.tdata  = dat2;
  assign m00_axis.tlast  = last2;

endmodule

// File: tb/tb_axis_dac_scaler.sv
// Directed bench for axis_dac_scaler with default parameters.
// Inputs change just after the falling edge; outputs are read before the next rising edge.
module tb_axis_dac_scaler;

  logic        clk;
  logic        rst_n;
  logic [4:0]  shift;
  logic        round_en;
  logic        sat_en;
  logic        offset_bin;
  logic        clr_ovf;
  logic [15:0] ovf_count;
  logic        ovf_sticky;

  int total;
  int bad;

  axis_dac_scaler_if #(.WIDTH(32)) s_if ();
  axis_dac_scaler_if #(.WIDTH(8))  m_if ();

  axis_dac_scaler dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis         (s_if),
    .m00_axis         (m_if),
    .shift            (shift),
    .round_en         (round_en),
    .sat_en           (sat_en),
    .offset_bin       (offset_bin),
    .clr_ovf          (clr_ovf),
    .ovf_count        (ovf_count),
    .ovf_sticky       (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat with m00 tready high: not visible one cycle after accept, visible after two.
  task automatic beat(input logic [31:0] x, input logic rnd, input logic sat, input logic ob,
                      input logic [7:0] exp, input string tag);
    @(negedge clk);
    s_if.tdata  = x;
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b0;
    round_en    = rnd;
    sat_en      = sat;
    offset_bin  = ob;
    #1;
    chk({tag, "_rdy"}, 32'(s_if.tready), 32'd1);
    @(negedge clk);
    s_if.tvalid = 1'b0;
    chk({tag, "_early"}, 32'(m_if.tvalid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(m_if.tvalid), 32'd1);
    chk(tag, 32'(m_if.tdata), 32'(exp));
  endtask

  initial begin
    int in_idx;
    int out_idx;
    int cyc;
    logic stalled;
    logic [7:0] held_dat;
    logic held_last;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    shift = '0;
    round_en = 1'b0;
    sat_en = 1'b1;
    offset_bin = 1'b0;
    clr_ovf = 1'b0;
    s_if.tdata = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b1;

    // Reset state
    #2;
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_tdata", 32'(m_if.tdata), 32'd0);
    chk("rst_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_tready", 32'(s_if.tready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Floor and rounding
    beat(32'h0000_5000, 1'b0, 1'b1, 1'b0, 8'h05, "floor");
    beat(32'h0000_1800, 1'b0, 1'b1, 1'b0, 8'h01, "pos_floor");
    beat(32'h0000_1800, 1'b1, 1'b1, 1'b0, 8'h02, "pos_round");
    beat(32'hFFFF_E800, 1'b0, 1'b1, 1'b0, 8'hFE, "neg_floor");
    beat(32'hFFFF_E800, 1'b1, 1'b1, 1'b0, 8'hFF, "neg_round");
    chk("no_ovf_yet", 32'(ovf_count), 32'd0);

    // Saturation and wrap
    beat(32'h0010_0000, 1'b0, 1'b1, 1'b0, 8'h7F, "sat_pos");
    beat(32'h0010_0000, 1'b0, 1'b0, 1'b0, 8'h00, "wrap_pos");
    beat(32'hFFF0_0000, 1'b0, 1'b1, 1'b0, 8'h80, "sat_neg");
    chk("ovf_count3", 32'(ovf_count), 32'd3);
    chk("ovf_sticky1", 32'(ovf_sticky), 32'd1);

    // Clear coincident with an overflowing beat entering stage 2
    @(negedge clk);
    s_if.tdata  = 32'h0010_0000;
    s_if.tvalid = 1'b1;
    sat_en      = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    clr_ovf     = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("clr_count", 32'(ovf_count), 32'd0);
    chk("clr_sticky", 32'(ovf_sticky), 32'd0);
    chk("clr_beat", 32'(m_if.tdata), 32'h7F);

    // Offset binary
    beat(32'h0000_0000, 1'b0, 1'b1, 1'b1, 8'h80, "ob_zero");
    beat(32'h0007_F000, 1'b0, 1'b1, 1'b1, 8'hFF, "ob_max");
    offset_bin = 1'b0;
    round_en   = 1'b0;

    // Full throughput: 8 back-to-back beats, 8 consecutive output cycles
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (c < 8) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'((c + 1) * 32'h1000);
        s_if.tlast  = (c == 7);
      end else begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
      end
      #1;
      if (c < 8) chk("tp_rdy", 32'(s_if.tready), 32'd1);
      if (c >= 2 && c <= 9) begin
        chk("tp_vld", 32'(m_if.tvalid), 32'd1);
        chk("tp_dat", 32'(m_if.tdata), 32'(c - 1));
        chk("tp_last", 32'(m_if.tlast), 32'(c == 9));
      end else begin
        chk("tp_idle", 32'(m_if.tvalid), 32'd0);
      end
    end

    // Random back-pressure: in-order, tlast only on the last beat, stable while stalled
    in_idx   = 0;
    out_idx  = 0;
    cyc      = 0;
    stalled  = 1'b0;
    held_dat = '0;
    held_last = 1'b0;
    while (out_idx < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      s_if.tvalid = (in_idx < 8);
      s_if.tdata  = 32'((in_idx + 1) * 32'h1000);
      s_if.tlast  = (in_idx == 7);
      m_if.tready = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        chk("bp_hold_vld", 32'(m_if.tvalid), 32'd1);
        chk("bp_hold_dat", 32'(m_if.tdata), 32'(held_dat));
        chk("bp_hold_last", 32'(m_if.tlast), 32'(held_last));
      end
      if (m_if.tvalid && m_if.tready) begin
        chk("bp_dat", 32'(m_if.tdata), 32'(out_idx + 1));
        chk("bp_last", 32'(m_if.tlast), 32'(out_idx == 7));
        out_idx++;
        stalled = 1'b0;
      end else if (m_if.tvalid) begin
        stalled   = 1'b1;
        held_dat  = m_if.tdata;
        held_last = m_if.tlast;
      end else begin
        stalled = 1'b0;
      end
      if (s_if.tvalid && s_if.tready) in_idx++;
    end
    chk("bp_count", 32'(out_idx), 32'd8);
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    #1;
    chk("bp_drained", 32'(m_if.tvalid), 32'd0);

    // Fill both stages with downstream stalled
    m_if.tready = 1'b0;
    @(negedge clk);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h0010_0000;
    sat_en      = 1'b1;
    @(negedge clk);
    s_if.tdata  = 32'h0000_2000;
    @(negedge clk);
    s_if.tdata  = 32'h0000_5000;
    #1;
    chk("full_rdy", 32'(s_if.tready), 32'd0);
    chk("full_vld", 32'(m_if.tvalid), 32'd1);
    chk("full_dat", 32'(m_if.tdata), 32'h7F);
    chk("full_ovf", 32'(ovf_count), 32'd1);
    m_if.tready = 1'b1;
    #1;
    chk("resume_rdy", 32'(s_if.tready), 32'd1);
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b0;
    #1;
    // Reset while both stages are occupied
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(m_if.tvalid), 32'd0);
    chk("arst_ovf", 32'(ovf_count), 32'd0);
    chk("arst_rdy", 32'(s_if.tready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    beat(32'h0000_3000, 1'b0, 1'b1, 1'b0, 8'h03, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
